cprv_dmem_resp: RTL



---
 rtl/cprv_pkg.sv | 20 ++
 rtl/cprv_dmem_array.sv | 31 +++
 rtl/cprv_dmem_resp.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cprv_pkg.sv
// cprv_pkg -- definitions shared by the cprv core memory-side blocks.
//   dmem_state_e : state encoding of the data-memory responder FSM
//   DWORD_BYTES  : bytes per doubleword access
//   DWORD_OFF_W  : width of the byte offset inside a doubleword
//   OPC_LOAD/OPC_STORE : memory-stage opcodes
package cprv_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DWORD_BYTES = 8;
    localparam int DWORD_OFF_W = 3;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/cprv_dmem_array.sv
// cprv_dmem_array -- DEPTH x DATA_WIDTH word array, single port,
// synchronous write and asynchronous read. Kept separate so it can be
// replaced by a BRAM macro. Contents are not reset.
//   clk   : clock
//   we    : write enable (writes wdata at idx on the rising edge)
//   idx   : word index shared by read and write
//   wdata : write data
//   rdata : combinational read of the word at idx
module cprv_dmem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/cprv_dmem_resp.sv
// cprv_dmem_resp -- data-memory responder at the far end of the memory
// stage's dmem request/response handshake. One request outstanding at a
// time, fixed LATENCY cycles from accept to response valid; every request
// (load or store) returns a response beat held until consumed.
//
// Optional build macro: CPRV_DMEM_MISALIGN_CHK_EN adds misalign_dmem_o,
// flags responses of requests with addr[2:0]!=0 and suppresses such stores.
//
// Ports:
//   clk, rst        : clock, async active-high reset
//   valid_dmem_i    : request valid          ready_dmem_o : request ready
//   addr_dmem_i     : byte address           wdata_dmem_i : store data
//   w_en_dmem_i     : 1 = store, 0 = load
//   valid_dmem_o    : response valid         ready_dmem_i : response ready
//   rdata_dmem_o    : load data or echoed store data
//   misalign_dmem_o : (macro only) response belongs to a misaligned request
//
// state     | meaning
// DMEM_IDLE | no request outstanding, ready for a new one
// DMEM_WAIT | request accepted, counting down the access latency
// DMEM_RESP | response valid, held until ready_dmem_i
module cprv_dmem_resp
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_dmem_i,
    output logic                  ready_dmem_o,
    input  logic [DATA_WIDTH-1:0] addr_dmem_i,
    input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
    input  logic                  w_en_dmem_i,
    output logic                  valid_dmem_o,
    input  logic                  ready_dmem_i,
    output logic [DATA_WIDTH-1:0] rdata_dmem_o
`ifdef CPRV_DMEM_MISALIGN_CHK_EN
    ,
    output logic                  misalign_dmem_o
`endif
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q;
    logic [IDX_W-1:0]      cap_idx_q;
    logic [DATA_WIDTH-1:0] cap_wdata_q;
    logic                  cap_we_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  accept;
    logic                  enter_resp;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      arr_idx;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  unused_addr;

    // Upper address bits wrap; the byte offset only matters for the
    // optional misalignment check.
    assign unused_addr = ^{addr_dmem_i[DATA_WIDTH-1:IDX_W+DWORD_OFF_W],
                           addr_dmem_i[DWORD_OFF_W-1:0]};

    assign req_idx = addr_dmem_i[IDX_W+DWORD_OFF_W-1:DWORD_OFF_W];
    assign accept  = valid_dmem_i & ready_dmem_o;

    // On an accept edge the incoming request is not yet captured, so the
    // array port and response mux look at the live inputs.
    assign arr_idx = accept ? req_idx : cap_idx_q;

`ifdef CPRV_DMEM_MISALIGN_CHK_EN
    logic req_misalign;
    logic cap_mis_q;
    logic mis_q;

    assign req_misalign    = |addr_dmem_i[DWORD_OFF_W-1:0];
    assign arr_we          = accept & w_en_dmem_i & ~req_misalign;
    assign misalign_dmem_o = mis_q;
`else
    assign arr_we = accept & w_en_dmem_i;
`endif

    always_comb begin
        resp_data = arr_rdata;
        if (accept) begin
            if (w_en_dmem_i) resp_data = wdata_dmem_i;
        end else if (cap_we_q) begin
            resp_data = cap_wdata_q;
        end
    end

    // Covers both a fresh entry and a back-to-back accept inside RESP.
    assign enter_resp = (state_d == DMEM_RESP) && ((state_q != DMEM_RESP) || accept);

    cprv_dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_dmem_i),
        .rdata (arr_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: begin
                if (accept) state_d = (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
            end
            DMEM_WAIT: begin
                if (cnt_q == 4'd1) state_d = DMEM_RESP;
            end
            DMEM_RESP: begin
                if (ready_dmem_i) begin
                    if (accept) state_d = (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
                    else        state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_dmem_o = 1'b0;
        valid_dmem_o = 1'b0;
        case (state_q)
            DMEM_IDLE: ready_dmem_o = 1'b1;
            DMEM_WAIT: ready_dmem_o = 1'b0;
            DMEM_RESP: begin
                ready_dmem_o = ready_dmem_i;
                valid_dmem_o = 1'b1;
            end
            default: ready_dmem_o = 1'b0;
        endcase
    end

    // Latency counter, captured request and response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            cap_we_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (accept) begin
                cnt_q       <= LAT_M1;
                cap_idx_q   <= req_idx;
                cap_wdata_q <= wdata_dmem_i;
                cap_we_q    <= w_en_dmem_i;
            end else if ((state_q == DMEM_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= resp_data;
            end
        end
    end

`ifdef CPRV_DMEM_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_mis_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            if (accept) cap_mis_q <= req_misalign;
            if (enter_resp) mis_q <= accept ? req_misalign : cap_mis_q;
        end
    end
`endif

    assign rdata_dmem_o = rdata_q;

endmodule
